// File: rtl/ex_mem_fwd_pkg.sv
//------------------------------------------------------------------------------
// Module   : ex_mem_fwd_pkg
// Brief    : Shared widths, forward-select type and encodings for ex_mem_fwd.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ex_mem_fwd_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

endpackage

`default_nettype wire

// File: rtl/ex_mem_fwd_fwd_unit.sv
//------------------------------------------------------------------------------
// Module   : fwd_unit
// Brief    : Combinational ALU-operand forwarding selects (EX/MEM over MEM/WB).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_unit
  import ex_mem_fwd_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W
) (
  input  logic             ex_mem_reg_write,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic             mem_wb_reg_write,
  input  logic [REG_W-1:0] mem_wb_rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output fwd_sel_t         fwd_a,
  output fwd_sel_t         fwd_b
);

  // Register 0 is hard-wired, so a pending write to it never forwards.
  logic w_ex_mem_live;
  logic w_mem_wb_live;

  assign w_ex_mem_live = ex_mem_reg_write && (ex_mem_rd != '0);
  assign w_mem_wb_live = mem_wb_reg_write && (mem_wb_rd != '0);

  always_comb begin
    fwd_a = FWD_RF;
    if (w_ex_mem_live && (ex_mem_rd == rs)) begin
      fwd_a = FWD_EXMEM;
    end else if (w_mem_wb_live && (mem_wb_rd == rs)) begin
      fwd_a = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (w_ex_mem_live && (ex_mem_rd == rt)) begin
      fwd_b = FWD_EXMEM;
    end else if (w_mem_wb_live && (mem_wb_rd == rt)) begin
      fwd_b = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_fwd.sv
//------------------------------------------------------------------------------
// Module   : ex_mem_fwd
// Brief    : EX/MEM pipeline register fused with the data-forwarding unit.
//            Optional stall/flush inputs when EX_MEM_STALL_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_mem_fwd
  import ex_mem_fwd_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef EX_MEM_STALL_EN
  input  logic              stall_i,
  input  logic              flush_i,
`endif
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUOut_i,
  input  logic [DATA_W-1:0] mux7_i,
  input  logic [REG_W-1:0]  mux8_i,
  output logic              MemToReg_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] ALUOut_o,
  output logic [DATA_W-1:0] mux7_o,
  output logic [REG_W-1:0]  mux8_o,
  input  logic [REG_W-1:0]  ID_EX_RegRs_i,
  input  logic [REG_W-1:0]  ID_EX_RegRt_i,
  input  logic              MEM_WB_RegWrite_i,
  input  logic [REG_W-1:0]  MEM_WB_RegRd_i,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o
);

  logic              r_mem_to_reg;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] r_mux7;
  logic [REG_W-1:0]  r_mux8;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_out    <= '0;
      r_mux7       <= '0;
      r_mux8       <= '0;
`ifdef EX_MEM_STALL_EN
    end else if (flush_i) begin
      // A flush turns the slot into a bubble; data fields are don't-care.
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_out    <= ALUOut_i;
      r_mux7       <= mux7_i;
      r_mux8       <= mux8_i;
    end else if (!stall_i) begin
`else
    end else begin
`endif
      r_mem_to_reg <= MemToReg_i;
      r_reg_write  <= RegWrite_i;
      r_mem_read   <= MemRead_i;
      r_mem_write  <= MemWrite_i;
      r_alu_out    <= ALUOut_i;
      r_mux7       <= mux7_i;
      r_mux8       <= mux8_i;
    end
  end

  assign MemToReg_o = r_mem_to_reg;
  assign RegWrite_o = r_reg_write;
  assign MemRead_o  = r_mem_read;
  assign MemWrite_o = r_mem_write;
  assign ALUOut_o   = r_alu_out;
  assign mux7_o     = r_mux7;
  assign mux8_o     = r_mux8;

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;

  fwd_unit #(
    .REG_W (REG_W)
  ) u_fwd_unit (
    .ex_mem_reg_write (r_reg_write),
    .ex_mem_rd        (r_mux8),
    .mem_wb_reg_write (MEM_WB_RegWrite_i),
    .mem_wb_rd        (MEM_WB_RegRd_i),
    .rs               (ID_EX_RegRs_i),
    .rt               (ID_EX_RegRt_i),
    .fwd_a            (w_fwd_a),
    .fwd_b            (w_fwd_b)
  );

  assign ForwardA_o = w_fwd_a;
  assign ForwardB_o = w_fwd_b;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_fwd.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_mem_fwd
// Brief    : Self-checking bench for ex_mem_fwd against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_mem_fwd;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              MemToReg_i, RegWrite_i, MemRead_i, MemWrite_i;
  logic [DATA_W-1:0] ALUOut_i, mux7_i;
  logic [REG_W-1:0]  mux8_i;
  logic              MemToReg_o, RegWrite_o, MemRead_o, MemWrite_o;
  logic [DATA_W-1:0] ALUOut_o, mux7_o;
  logic [REG_W-1:0]  mux8_o;
  logic [REG_W-1:0]  ID_EX_RegRs_i, ID_EX_RegRt_i, MEM_WB_RegRd_i;
  logic              MEM_WB_RegWrite_i;
  logic [1:0]        ForwardA_o, ForwardB_o;

  ex_mem_fwd #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
`ifdef EX_MEM_STALL_EN
    .stall_i           (stall_i),
    .flush_i           (flush_i),
`endif
    .MemToReg_i        (MemToReg_i),
    .RegWrite_i        (RegWrite_i),
    .MemRead_i         (MemRead_i),
    .MemWrite_i        (MemWrite_i),
    .ALUOut_i          (ALUOut_i),
    .mux7_i            (mux7_i),
    .mux8_i            (mux8_i),
    .MemToReg_o        (MemToReg_o),
    .RegWrite_o        (RegWrite_o),
    .MemRead_o         (MemRead_o),
    .MemWrite_o        (MemWrite_o),
    .ALUOut_o          (ALUOut_o),
    .mux7_o            (mux7_o),
    .mux8_o            (mux8_o),
    .ID_EX_RegRs_i     (ID_EX_RegRs_i),
    .ID_EX_RegRt_i     (ID_EX_RegRt_i),
    .MEM_WB_RegWrite_i (MEM_WB_RegWrite_i),
    .MEM_WB_RegRd_i    (MEM_WB_RegRd_i),
    .ForwardA_o        (ForwardA_o),
    .ForwardB_o        (ForwardB_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the EX/MEM slot contents.
  logic              m_m2r, m_rw, m_mr, m_mw;
  logic [DATA_W-1:0] m_alu, m_m7;
  logic [REG_W-1:0]  m_m8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Forwarding rule: newest live producer of the source register wins.
  function automatic logic [1:0] ref_fwd(input logic [REG_W-1:0] src);
    if (m_rw && m_m8 != 0 && m_m8 == src) return 2'b10;
    if (MEM_WB_RegWrite_i && MEM_WB_RegRd_i != 0 && MEM_WB_RegRd_i == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clock_edge();
    @(posedge clk);
    if (rst_i) begin
      {m_m2r, m_rw, m_mr, m_mw} = 4'b0;
      m_alu = '0; m_m7 = '0; m_m8 = '0;
    end else if (flush_i) begin
      {m_m2r, m_rw, m_mr, m_mw} = 4'b0;
      m_alu = ALUOut_i; m_m7 = mux7_i; m_m8 = mux8_i;
    end else if (!stall_i) begin
      {m_m2r, m_rw, m_mr, m_mw} = {MemToReg_i, RegWrite_i, MemRead_i, MemWrite_i};
      m_alu = ALUOut_i; m_m7 = mux7_i; m_m8 = mux8_i;
    end
    @(negedge clk);
    check("MemToReg", MemToReg_o, m_m2r);
    check("RegWrite", RegWrite_o, m_rw);
    check("MemRead",  MemRead_o,  m_mr);
    check("MemWrite", MemWrite_o, m_mw);
    check("ALUOut",   ALUOut_o,   m_alu);
    check("mux7",     mux7_o,     m_m7);
    check("mux8",     mux8_o,     m_m8);
  endtask

  task automatic check_fwd();
    #1;
    check("ForwardA", ForwardA_o, ref_fwd(ID_EX_RegRs_i));
    check("ForwardB", ForwardB_o, ref_fwd(ID_EX_RegRt_i));
  endtask

  // Small index pool so matches between stages happen often.
  function automatic logic [REG_W-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd7;
      2: return 5'd21;
      default: return REG_W'($urandom);
    endcase
  endfunction

  initial begin
    rst_i = 1'b1;
    {MemToReg_i, RegWrite_i, MemRead_i, MemWrite_i} = 4'b0100;
    ALUOut_i = 32'hdead_beef; mux7_i = 32'h1234_5678; mux8_i = 5'b01010;
    ID_EX_RegRs_i = 5'b10101; ID_EX_RegRt_i = 5'b10110;
    MEM_WB_RegRd_i = 5'b11111; MEM_WB_RegWrite_i = 1'b1;
    @(negedge clk);

    // Reset
    clock_edge();
    check("rst_mux8", mux8_o, 0);
    check_fwd();
    check("rst_fwdA", ForwardA_o, 2'b00);
    check("rst_fwdB", ForwardB_o, 2'b00);

    // Latch, EX/MEM forward on Rt
    rst_i = 1'b0;
    {MemToReg_i, RegWrite_i, MemRead_i, MemWrite_i} = 4'b1110;
    ALUOut_i = 0; mux7_i = 155; mux8_i = 5'b10110;
    clock_edge();
    check("lat_mux7", mux7_o, 155);
    check_fwd();
    check("lat_fwdA", ForwardA_o, 2'b00);
    check("lat_fwdB", ForwardB_o, 2'b10);

    // MEM/WB forward on Rs
    RegWrite_i = 1'b0;
    clock_edge();
    MEM_WB_RegRd_i = 5'b10101; MEM_WB_RegWrite_i = 1'b1;
    check_fwd();
    check("mw_fwdA", ForwardA_o, 2'b01);
    check("mw_fwdB", ForwardB_o, 2'b00);

    // Priority: both stages match
    RegWrite_i = 1'b1; mux8_i = 5'b00111;
    clock_edge();
    ID_EX_RegRs_i = 5'b00111; ID_EX_RegRt_i = 5'b00111; MEM_WB_RegRd_i = 5'b00111;
    check_fwd();
    check("pri_fwdA", ForwardA_o, 2'b10);
    check("pri_fwdB", ForwardB_o, 2'b10);

    // Register zero never forwards
    mux8_i = 5'd0;
    clock_edge();
    ID_EX_RegRs_i = 0; ID_EX_RegRt_i = 0; MEM_WB_RegRd_i = 0;
    check_fwd();
    check("zero_fwdA", ForwardA_o, 2'b00);
    check("zero_fwdB", ForwardB_o, 2'b00);

`ifdef EX_MEM_STALL_EN
    // Stall holds, flush zeroes controls, reset beats flush
    RegWrite_i = 1'b1; MemRead_i = 1'b1; mux8_i = 5'd9; ALUOut_i = 32'h55;
    clock_edge();
    stall_i = 1'b1; mux8_i = 5'd3; ALUOut_i = 32'h66;
    clock_edge();
    check("stall_mux8", mux8_o, 5'd9);
    flush_i = 1'b1;
    clock_edge();
    check("flush_rw", RegWrite_o, 1'b0);
    rst_i = 1'b1;
    clock_edge();
    check("rstfl_alu", ALUOut_o, 0);
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 15) == 0);
`ifdef EX_MEM_STALL_EN
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
`endif
      {MemToReg_i, RegWrite_i, MemRead_i, MemWrite_i} = 4'($urandom);
      ALUOut_i = $urandom; mux7_i = $urandom; mux8_i = pick_reg();
      clock_edge();
      ID_EX_RegRs_i = pick_reg();
      ID_EX_RegRt_i = ($urandom_range(0, 3) == 0) ? ID_EX_RegRs_i : pick_reg();
      MEM_WB_RegRd_i = pick_reg();
      MEM_WB_RegWrite_i = 1'($urandom);
      check_fwd();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
